// File: rtl/fpga_reset_sequencer.sv
// Board-level reset sequencer: lock/button sync, debounce, staged release
// of peripheral and core resets, exit-status capture and a heartbeat LED.
module fpga_reset_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES      = 1000000,
  parameter int unsigned HOLD_CYCLES          = 1024,
  parameter int unsigned STAGGER_CYCLES       = 64,
  parameter bit          BTN_ACTIVE_HIGH      = 1'b1,
  parameter int unsigned CLK_LED_COUNT_LENGTH = 27
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clk_locked_i,
  input  logic        btn_rst_i,
  input  logic        exit_valid_i,
  input  logic [31:0] exit_value_i,
  output logic        periph_rst_no,
  output logic        core_rst_no,
  output logic        rst_led_o,
  output logic        clk_led_o,
  output logic        exit_done_o,
  output logic        exit_value_o,
  output logic [1:0]  state_o
);

  localparam int unsigned SMAX =
    (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
  localparam int unsigned SW = $clog2(SMAX + 1);
  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic BTN_IDLE = !BTN_ACTIVE_HIGH;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    STAGGER   = 2'd2,
    RUN       = 2'd3
  } state_e;

  logic [1:0] lock_q;
  logic [1:0] btn_q;
  logic       lock_sync;
  logic       btn_sync;
  logic          db_q;
  logic [DW-1:0] db_cnt_q;
  state_e        state_q, state_d;
  logic [SW-1:0] cnt_q, cnt_d;
  logic          exit_done_q;
  logic          exit_val_q;
  logic [CLK_LED_COUNT_LENGTH-1:0] hb_q;
  logic unused_exit_bits;

  assign unused_exit_bits = ^exit_value_i[31:1];

  // Button flops reset to the raw idle level so btn_sync starts released.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      lock_q <= 2'b00;
      btn_q  <= {2{BTN_IDLE}};
    end else begin
      lock_q <= {lock_q[0], clk_locked_i};
      btn_q  <= {btn_q[0], btn_rst_i};
    end
  end

  assign lock_sync = lock_q[1];
  assign btn_sync  = BTN_ACTIVE_HIGH ? btn_q[1] : ~btn_q[1];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      db_q     <= 1'b0;
      db_cnt_q <= '0;
    end else if (btn_sync == db_q) begin
      db_cnt_q <= '0;
    end else if (db_cnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
      db_q     <= btn_sync;
      db_cnt_q <= '0;
    end else begin
      db_cnt_q <= db_cnt_q + DW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= WAIT_LOCK;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!lock_sync) begin
      state_d = WAIT_LOCK;
    end else if (db_q && (state_q == STAGGER || state_q == RUN)) begin
      state_d = HOLD;
    end else begin
      unique case (state_q)
        WAIT_LOCK: begin
          if (!db_q) state_d = HOLD;
        end
        HOLD: begin
          if (db_q)
            cnt_d = '0;
          else if (cnt_q == SW'(HOLD_CYCLES - 1))
            state_d = STAGGER;
          else
            cnt_d = cnt_q + SW'(1);
        end
        STAGGER: begin
          if (cnt_q == SW'(STAGGER_CYCLES - 1))
            state_d = RUN;
          else
            cnt_d = cnt_q + SW'(1);
        end
        RUN: ;
        default: state_d = WAIT_LOCK;
      endcase
    end
    if (state_d != state_q) cnt_d = '0;
  end

  // Exit status only lives inside a RUN period.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      exit_done_q <= 1'b0;
      exit_val_q  <= 1'b0;
    end else if (state_q != RUN) begin
      exit_done_q <= 1'b0;
      exit_val_q  <= 1'b0;
    end else if (exit_valid_i && !exit_done_q) begin
      exit_done_q <= 1'b1;
      exit_val_q  <= exit_value_i[0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) hb_q <= '0;
    else         hb_q <= hb_q + 1'b1;
  end

  assign periph_rst_no = (state_q == STAGGER) || (state_q == RUN);
  assign core_rst_no   = (state_q == RUN);
  assign rst_led_o     = core_rst_no;
  assign clk_led_o     = hb_q[CLK_LED_COUNT_LENGTH-1];
  assign exit_done_o   = exit_done_q;
  assign exit_value_o  = exit_val_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_fpga_reset_sequencer.sv
// Directed and randomized checks of the reset sequencer against a
// timing-rule reference model.
module tb_fpga_reset_sequencer;

  localparam int H = 16;
  localparam int S = 8;
  localparam int D = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, lock, btn, ev;
  logic [31:0] evl;
  logic        p_rst, c_rst, led_r, led_c, xd, xv;
  logic [1:0]  st;

  logic        rst_n1, lock1, btn1;
  logic        p1, c1, lr1, lc1, xd1, xv1;
  logic [1:0]  st1;

  fpga_reset_sequencer #(
    .DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H), .STAGGER_CYCLES(S),
    .BTN_ACTIVE_HIGH(1'b1), .CLK_LED_COUNT_LENGTH(4)
  ) u0 (
    .clk_i(clk), .rst_ni(rst_n), .clk_locked_i(lock),
    .btn_rst_i(btn), .exit_valid_i(ev), .exit_value_i(evl),
    .periph_rst_no(p_rst), .core_rst_no(c_rst), .rst_led_o(led_r),
    .clk_led_o(led_c), .exit_done_o(xd), .exit_value_o(xv),
    .state_o(st)
  );

  fpga_reset_sequencer #(
    .DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H), .STAGGER_CYCLES(S),
    .BTN_ACTIVE_HIGH(1'b0), .CLK_LED_COUNT_LENGTH(4)
  ) u1 (
    .clk_i(clk), .rst_ni(rst_n1), .clk_locked_i(lock1),
    .btn_rst_i(btn1), .exit_valid_i(1'b0), .exit_value_i(32'h0),
    .periph_rst_no(p1), .core_rst_no(c1), .rst_led_o(lr1),
    .clk_led_o(lc1), .exit_done_o(xd1), .exit_value_o(xv1),
    .state_o(st1)
  );

  int n_eval = 0;
  int n_fail = 0;
  int hb = 0;
  bit rm_on = 1'b0;

  // Reference model: run length of consecutive "lock seen" edges.
  int n_ok;
  bit l1, l2;
  bit m_done, m_val;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_eval++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    bit was_run;
    bit ok;
    was_run = (n_ok >= 1 + H + S);
    ok = l2;
    l2 = l1;
    l1 = lock;
    if (!was_run) begin
      m_done = 1'b0;
      m_val  = 1'b0;
    end else if (ev && !m_done) begin
      m_done = 1'b1;
      m_val  = evl[0];
    end
    n_ok = ok ? n_ok + 1 : 0;
  endtask

  task automatic model_check();
    int es;
    if (n_ok == 0)              es = 0;
    else if (n_ok < 1 + H)      es = 1;
    else if (n_ok < 1 + H + S)  es = 2;
    else                        es = 3;
    chk("rnd_state",  32'(st), 32'(es));
    chk("rnd_periph", 32'(p_rst), 32'(es >= 2));
    chk("rnd_core",   32'(c_rst), 32'(es == 3));
    chk("rnd_led",    32'(led_r), 32'(es == 3));
    chk("rnd_xdone",  32'(xd), 32'(m_done));
    chk("rnd_xval",   32'(xv), 32'(m_val));
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      if (rm_on) model_step();
      hb = rst_n ? hb + 1 : 0;
      #1;
      chk("heartbeat", 32'(led_c), 32'((hb % 16) / 8));
      if (rm_on) model_check();
    end
  endtask

  task automatic chk0(input string tag, input int es);
    chk({tag, "_state"},  32'(st), 32'(es));
    chk({tag, "_periph"}, 32'(p_rst), 32'(es >= 2));
    chk({tag, "_core"},   32'(c_rst), 32'(es == 3));
    chk({tag, "_led"},    32'(led_r), 32'(es == 3));
  endtask

  task automatic chk1(input string tag, input int es);
    chk({tag, "_state1"},  32'(st1), 32'(es));
    chk({tag, "_periph1"}, 32'(p1), 32'(es >= 2));
    chk({tag, "_core1"},   32'(c1), 32'(es == 3));
    chk({tag, "_led1"},    32'(lr1), 32'(es == 3));
  endtask

  initial begin
    int prun;
    rst_n = 0; rst_n1 = 0;
    lock = 1; lock1 = 1;
    btn = 0; btn1 = 1;
    ev = 0; evl = '0;

    cyc(3);
    chk0("reset", 0);
    chk1("reset", 0);
    chk("reset_xd", 32'(xd), 0);
    chk("reset_xv", 32'(xv), 0);
    chk("reset_clkled1", 32'(lc1), 0);

    // Power-up, both instances
    rst_n = 1; rst_n1 = 1;
    cyc(2);
    chk0("pu_e1", 0);
    chk1("pu_e1", 0);
    cyc(1);
    chk0("pu_e2", 1);
    chk1("pu_e2", 1);
    cyc(15);
    chk0("pu_e17", 1);
    cyc(1);
    chk0("pu_e18", 2);
    chk1("pu_e18", 2);
    cyc(7);
    chk0("pu_e25", 2);
    cyc(1);
    chk0("pu_e26", 3);
    chk1("pu_e26", 3);

    // Active-low button on u1
    btn1 = 0;
    cyc(4);
    btn1 = 1;
    cyc(2);
    chk1("lowbtn_p5", 3);
    cyc(1);
    chk1("lowbtn_p6", 1);

    // Lock loss on u0
    lock = 0;
    cyc(1);
    lock = 1;
    cyc(1);
    chk0("ll_e2", 3);
    cyc(1);
    chk0("ll_e3", 0);
    cyc(1);
    chk0("ll_e4", 1);
    cyc(15);
    chk0("ll_e19", 1);
    cyc(1);
    chk0("ll_e20", 2);
    cyc(7);
    chk0("ll_e27", 2);
    cyc(1);
    chk0("ll_e28", 3);

    // Bouncing button never resets
    repeat (5) begin
      btn = 1;
      cyc(3);
      chk0("bounce_on", 3);
      btn = 0;
      cyc(1);
      chk0("bounce_off", 3);
    end
    cyc(4);
    chk0("bounce_end", 3);

    // Clean press
    btn = 1;
    cyc(4);
    btn = 0;
    cyc(2);
    chk0("press_p5", 3);
    cyc(1);
    chk0("press_p6", 1);
    cyc(18);
    chk0("press_p24", 1);
    cyc(1);
    chk0("press_p25", 2);
    cyc(7);
    chk0("press_p32", 2);
    cyc(1);
    chk0("press_p33", 3);

    // Exit capture
    chk("exit_pre", 32'(xd), 0);
    ev = 1; evl = 32'h1;
    cyc(1);
    chk("exit1_done", 32'(xd), 1);
    chk("exit1_val", 32'(xv), 1);
    evl = 32'h0;
    cyc(1);
    chk("exit2_done", 32'(xd), 1);
    chk("exit2_val", 32'(xv), 1);
    ev = 0;
    cyc(2);
    chk("exit3_val", 32'(xv), 1);
    btn = 1;
    cyc(4);
    btn = 0;
    cyc(3);
    chk0("exitrst_p6", 1);
    chk("exitrst_p6_done", 32'(xd), 1);
    cyc(1);
    chk("exitrst_p7_done", 32'(xd), 0);
    chk("exitrst_p7_val", 32'(xv), 0);
    cyc(30);
    chk0("rerun", 3);

    // Mid-sequence reset aborts on the same edge
    rst_n = 0;
    cyc(1);
    chk0("midrst", 0);
    chk("midrst_xd", 32'(xd), 0);

    // Randomized phase against the reference model
    n_ok = 0; l1 = 0; l2 = 0; m_done = 0; m_val = 0;
    prun = 0;
    rm_on = 1'b1;
    rst_n = 1;
    for (int i = 0; i < 800; i++) begin
      cyc(1);
      if (lock) lock = ($urandom_range(79) != 0);
      else      lock = ($urandom_range(3) != 0);
      if (prun >= 3)  btn = 1'b0;
      else if (btn)   btn = ($urandom_range(1) == 0);
      else            btn = ($urandom_range(7) == 0);
      prun = btn ? prun + 1 : 0;
      ev  = ($urandom_range(9) == 0);
      evl = $urandom;
    end
    rm_on = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_eval, n_fail);
    $finish;
  end

endmodule

// File: doc/fpga_reset_sequencer.md
FPGA_RESET_SEQUENCER -- requirements
Module: fpga_reset_sequencer

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  DEBOUNCE_CYCLES  1000000  consecutive stable cycles needed to accept a button level change; legal range >=1
  HOLD_CYCLES      1024     cycles both resets stay asserted after lock, with the button released; legal range >=1
  STAGGER_CYCLES   64       cycles between peripheral and core reset release; legal range >=1
  BTN_ACTIVE_HIGH  1        1 = button pressed when high; 0 = pressed when low
  CLK_LED_COUNT_LENGTH  27  heartbeat counter width
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clk_i          in   1  generated system clock (clock-wizard output); the only clock
  rst_ni         in   1  reset, synchronous, active-low
  clk_locked_i   in   1  clock-wizard lock, asynchronous
  btn_rst_i      in   1  raw board reset button, asynchronous
  exit_valid_i   in   1  x_heep_system exit valid, clk_i domain
  exit_value_i   in   32 x_heep_system exit value
  periph_rst_no  out  1  peripheral-domain reset, active-low
  core_rst_no    out  1  x_heep_system rst_ni, active-low
  rst_led_o      out  1  equals core_rst_no
  clk_led_o      out  1  heartbeat, MSB of the free-running counter
  exit_done_o    out  1  sticky: exit observed in RUN
  exit_value_o   out  1  latched exit_value_i[0]
  state_o        out  2  FSM state: WAIT_LOCK=0, HOLD=1, STAGGER=2, RUN=3
REQ-003 Only one clock and one reset exist: clk_i, and rst_ni, which is synchronous and active-low.

Function
REQ-004 clk_locked_i and btn_rst_i SHALL each pass through a 2-flop synchronizer. btn_sync is the second stage, inverted when BTN_ACTIVE_HIGH=0, so that 1 means pressed.
REQ-005 Debounce: btn_db changes to btn_sync after btn_sync has differed from btn_db for DEBOUNCE_CYCLES consecutive cycles.
  - The counter clears on any cycle where the two are equal.
  - The counter width is $clog2(DEBOUNCE_CYCLES+1).
REQ-006 One shared stage counter, width $clog2(max(HOLD_CYCLES,STAGGER_CYCLES)+1), SHALL clear on every state change.
REQ-007 Transition priority SHALL be, each evaluated per edge:
  - (a) lock_sync=0 -> WAIT_LOCK from any state.
  - (b) btn_db=1 from STAGGER/RUN -> HOLD, counter cleared.
  - (c) normal progression.
REQ-008 WAIT_LOCK -> HOLD when lock_sync=1 and btn_db=0.
REQ-009 HOLD:
  - While btn_db=1, the counter is held at 0.
  - Otherwise, when counter==HOLD_CYCLES-1 -> STAGGER; else counter+1.
REQ-010 STAGGER: when counter==STAGGER_CYCLES-1 -> RUN; else counter+1.
REQ-011 RUN SHALL persist until rule (a) or (b) fires.
REQ-012 Outputs are decoded directly from the state register, with no combinational path from any input:
  - periph_rst_no=1 in STAGGER and RUN, else 0.
  - core_rst_no=1 in RUN only.
REQ-013 Exit capture: in RUN, when exit_valid_i=1 and exit_done_o=0, on the next edge exit_done_o<=1 and exit_value_o<=exit_value_i[0].
  - Further exit_valid_i pulses are ignored while exit_done_o=1.
REQ-014 exit_done_o and exit_value_o SHALL clear to 0 on the edge where the state is not RUN.
  - This makes every new reset sequence start with a clean exit status.
REQ-015 The heartbeat counter SHALL increment every cycle, wrap modulo 2^CLK_LED_COUNT_LENGTH, and be cleared only by rst_ni. The FSM and the button do not affect it.
REQ-016 When lock and button events occur simultaneously, lock loss (a) SHALL win.
REQ-017 With lock stable, the latency from entering HOLD to periph_rst_no=1 is HOLD_CYCLES edges. From periph_rst_no=1 to core_rst_no=1 is STAGGER_CYCLES edges.

Reset
REQ-018 While rst_ni=0 at an edge, the block SHALL set:
  - state=WAIT_LOCK, all counters=0, synchronizer flops=0 (the button flops to the not-pressed level), btn_db=0.
  - periph_rst_no=0, core_rst_no=0, rst_led_o=0, clk_led_o=0, exit_done_o=0, exit_value_o=0, state_o=0.
REQ-019 Asserting rst_ni mid-sequence SHALL abort it on the same edge, with no partial release.

Verification
REQ-020 The bench SHALL cover the following directed scenarios, using HOLD_CYCLES=16, STAGGER_CYCLES=8, DEBOUNCE_CYCLES=4 unless stated:
  - Power-up: clk_locked_i=1 held, rst_ni released at edge 0 -> state HOLD after edge 2; periph_rst_no=1 after edge 18; core_rst_no=1 after edge 26; state_o=3.
  - Lock loss: in RUN, drop clk_locked_i for 1 cycle -> both resets=0 two edges later, state_o=0. On relock -> full HOLD and STAGGER sequence repeats.
  - Button bounce: in RUN, toggle pressed level 3 cycles on / 1 off, repeated -> no reset. A clean 4-cycle press -> HOLD; sequence restarts only after release plus 16 cycles.
  - Exit capture: in RUN, drive exit_valid_i=1, exit_value_i=32'h1, then exit_valid_i=1, exit_value_i=0 -> exit_done_o=1, exit_value_o=1, unchanged by the second pulse. A subsequent button reset clears both to 0.
  - BTN_ACTIVE_HIGH=0: btn_rst_i held 1 -> normal release; btn_rst_i=0 for 4+ cycles -> reset sequence.
  - Heartbeat: CLK_LED_COUNT_LENGTH=4 -> clk_led_o toggles every 8 cycles, unaffected by lock loss; rst_ni=0 zeroes it.
